// File: rtl/piso_serial_tx.sv
// rtl/piso_serial_tx.sv - framed parallel-in serial-out transmitter (start 0, LSB-first data, stop 1)
//
// Ports:
//   Clk         system clock, rising edge
//   Rst         asynchronous active-high reset
//   Din         WIDTH-bit word, captured on a Load_valid && Load_ready edge
//   Load_valid  Din is valid and requests transmission
//   Load_ready  high only in IDLE
//   SerOut      registered serial line, idles high
//   Busy        a frame is in progress (START/DATA/PARITY/STOP)
//   Done        one-cycle pulse in the first IDLE cycle after STOP
//
// Optional: define PISO_PARITY_EN to insert an even-parity bit between DATA and STOP.

module piso_serial_tx #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] Din,
    input  logic             Load_valid,
    output logic             Load_ready,
    output logic             SerOut,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef PISO_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic             ser_q, ser_d;
    logic             done_q, done_d;
`ifdef PISO_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic             bit_end;
    logic [WIDTH-1:0] shifted;

    assign bit_end = (cyc_q == CYC_LAST);
    assign shifted = shift_q >> 1;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            bit_q    <= '0;
            cyc_q    <= '0;
            ser_q    <= 1'b1;
            done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            cyc_q    <= cyc_d;
            ser_q    <= ser_d;
            done_q   <= done_d;
`ifdef PISO_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // ser_d is the level the line takes in the state being entered, so SerOut
    // comes straight from a flop and changes exactly at bit boundaries.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        cyc_d    = cyc_q;
        ser_d    = ser_q;
        done_d   = 1'b0;
`ifdef PISO_PARITY_EN
        parity_d = parity_q;
`endif

        if (state_q != S_IDLE) begin
            cyc_d = bit_end ? '0 : cyc_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                ser_d = 1'b1;
                cyc_d = '0;
                bit_d = '0;
                if (Load_valid) begin
                    shift_d  = Din;
`ifdef PISO_PARITY_EN
                    parity_d = ^Din;
`endif
                    state_d  = S_START;
                    ser_d    = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    ser_d   = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shifted;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
`ifdef PISO_PARITY_EN
                        state_d = S_PARITY;
                        ser_d   = parity_q;
`else
                        state_d = S_STOP;
                        ser_d   = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + BW'(1);
                        ser_d = shifted[0];
                    end
                end
            end
`ifdef PISO_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    ser_d   = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    ser_d   = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ser_d   = 1'b1;
            end
        endcase
    end

    assign SerOut     = ser_q;
    assign Done       = done_q;
    assign Busy       = (state_q != S_IDLE);
    assign Load_ready = (state_q == S_IDLE);

endmodule

// File: tb/tb_piso_serial_tx.sv
// tb/tb_piso_serial_tx.sv - self-checking bench for piso_serial_tx (BIT_CYCLES=1 and BIT_CYCLES=4 instances)

module tb_piso_serial_tx;

`ifdef PISO_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int F = 10 + P;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic [7:0] Din = 8'h00;
    logic       Load_valid = 1'b0;
    logic       mon_en = 1'b0;

    logic ser_w  [2];
    logic busy_w [2];
    logic rdy_w  [2];
    logic done_w [2];

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Each instance gets a reference model: a queue of line levels still to be
    // sent, filled with a whole frame when a word is accepted.
    for (genvar g = 0; g < 2; g++) begin : mdl
        localparam int BC = (g == 0) ? 1 : 4;
        bit   q[$];
        logic m_ser = 1'b1, m_busy = 1'b0, m_rdy = 1'b1, m_done = 1'b0;
        bit   was_busy = 1'b0;

        piso_serial_tx #(.WIDTH(8), .BIT_CYCLES(BC)) u_dut (
            .Clk(Clk), .Rst(Rst), .Din(Din), .Load_valid(Load_valid),
            .Load_ready(rdy_w[g]), .SerOut(ser_w[g]), .Busy(busy_w[g]), .Done(done_w[g])
        );

        initial forever begin
            @(posedge Clk or posedge Rst);
            if (Rst) begin
                q.delete();
                m_ser = 1'b1; m_busy = 1'b0; m_rdy = 1'b1; m_done = 1'b0; was_busy = 1'b0;
            end else begin
                if (m_rdy && Load_valid) begin
                    for (int k = 0; k < 10 + P; k++) begin
                        bit b;
                        if (k == 0)           b = 1'b0;
                        else if (k <= 8)      b = Din[k-1];
                        else if (P && k == 9) b = ^Din;
                        else                  b = 1'b1;
                        for (int r = 0; r < BC; r++) q.push_back(b);
                    end
                end
                if (q.size() > 0) begin
                    m_ser = q.pop_front(); m_busy = 1'b1; m_rdy = 1'b0; m_done = 1'b0; was_busy = 1'b1;
                end else begin
                    m_ser = 1'b1; m_busy = 1'b0; m_rdy = 1'b1; m_done = was_busy; was_busy = 1'b0;
                end
            end
        end

        initial forever begin
            @(negedge Clk);
            if (mon_en) begin
                chk($sformatf("model_ser%0d", g),  ser_w[g],  m_ser);
                chk($sformatf("model_busy%0d", g), busy_w[g], m_busy);
                chk($sformatf("model_rdy%0d", g),  rdy_w[g],  m_rdy);
                chk($sformatf("model_done%0d", g), done_w[g], m_done);
            end
        end
    end

    typedef struct {
        logic [7:0] din;
        string      s;
    } vec_t;
    vec_t vecs[4];

    task automatic chk_reset_vals(input string tag);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("%s_ser%0d", tag, g),  ser_w[g],  1);
            chk($sformatf("%s_rdy%0d", tag, g),  rdy_w[g],  1);
            chk($sformatf("%s_busy%0d", tag, g), busy_w[g], 0);
            chk($sformatf("%s_done%0d", tag, g), done_w[g], 0);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge Clk);
        while (!(mdl[0].m_rdy && mdl[1].m_rdy) && n < 300) begin
            @(negedge Clk);
            n++;
        end
        chk("idle_wait_bound", (n < 300), 1);
    endtask

    task automatic run_vec(input logic [7:0] d, input string s);
        wait_idle();
        Din = d;
        Load_valid = 1'b1;
        for (int i = 0; i < s.len(); i++) begin
            @(negedge Clk);
            Load_valid = 1'b0;
            chk($sformatf("vec%02h_ser%0d", d, i), ser_w[0], (s.getc(i) == 8'h31));
            chk($sformatf("vec%02h_busy%0d", d, i), busy_w[0], 1);
            chk($sformatf("vec%02h_rdy%0d", d, i), rdy_w[0], 0);
        end
        @(negedge Clk);
        chk($sformatf("vec%02h_done", d), done_w[0], 1);
        chk($sformatf("vec%02h_idle_busy", d), busy_w[0], 0);
        chk($sformatf("vec%02h_idle_rdy", d), rdy_w[0], 1);
        @(negedge Clk);
        chk($sformatf("vec%02h_done_once", d), done_w[0], 0);
    endtask

    initial begin
        logic [10:0] f1, f2;
        int xfers;

`ifdef PISO_PARITY_EN
        vecs[0] = '{8'h07, "01110000011"};
        vecs[1] = '{8'hA5, "01010010101"};
        vecs[2] = '{8'h3C, "00011110001"};
        vecs[3] = '{8'hFF, "01111111101"};
        f1 = {1'b1, 1'b0, 8'h3C, 1'b0};
        f2 = {1'b1, 1'b0, 8'hC3, 1'b0};
`else
        vecs[0] = '{8'hA5, "0101001011"};
        vecs[1] = '{8'h3C, "0001111001"};
        vecs[2] = '{8'hFF, "0111111111"};
        vecs[3] = '{8'h81, "0100000011"};
        f1 = {1'b0, 1'b1, 8'h3C, 1'b0};
        f2 = {1'b0, 1'b1, 8'hC3, 1'b0};
`endif

        // Reset asserted between clock edges must take effect at once.
        #2 Rst = 1'b1;
        #1 chk_reset_vals("reset");
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        mon_en = 1'b1;

        for (int v = 0; v < 4; v++) run_vec(vecs[v].din, vecs[v].s);

        // Bit stretching on the BIT_CYCLES=4 instance with 8'h01.
        wait_idle();
        Din = 8'h01;
        Load_valid = 1'b1;
        for (int i = 0; i < 4 * F; i++) begin
            @(negedge Clk);
            Load_valid = 1'b0;
            chk($sformatf("stretch_ser%0d", i), ser_w[1], ((i >= 4 && i < 8) || i >= 36));
            chk($sformatf("stretch_busy%0d", i), busy_w[1], 1);
        end
        @(negedge Clk);
        chk("stretch_done", done_w[1], 1);
        chk("stretch_idle", busy_w[1], 0);

        // Back-to-back with Load_valid held high; Din changes mid-frame.
        wait_idle();
        Din = 8'h3C;
        Load_valid = 1'b1;
        xfers = 0;
        for (int n = 0; n <= 2 * F + 2; n++) begin
            if (n > 0) @(negedge Clk);
            if (n < 22 && Load_valid && rdy_w[0]) xfers++;
            if (n >= 1 && n <= F) chk($sformatf("b2b_f1_%0d", n), ser_w[0], f1[n-1]);
            if (n == F + 1) chk("b2b_done1", done_w[0], 1);
            if (n >= F + 2 && n <= 2 * F + 1) chk($sformatf("b2b_f2_%0d", n), ser_w[0], f2[n-F-2]);
            if (n == 2 * F + 2) chk("b2b_done2", done_w[0], 1);
            if (n == 5) Din = 8'hC3;
            if (n == 2 * F + 1) Load_valid = 1'b0;
        end
        chk("b2b_transfers", xfers, 2);

        // Reset during DATA bit 3 of 8'hFF, then a clean 8'h00 frame.
        wait_idle();
        Din = 8'hFF;
        Load_valid = 1'b1;
        @(negedge Clk);
        Load_valid = 1'b0;
        repeat (4) @(negedge Clk);
        chk("midrst_pre_ser", ser_w[0], 1);
        chk("midrst_pre_busy", busy_w[0], 1);
        #2 Rst = 1'b1;
        #1 chk_reset_vals("midrst");
        @(negedge Clk);
        Rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            chk($sformatf("midrst_nodone%0d", i), done_w[0], 0);
            chk($sformatf("midrst_nodone4_%0d", i), done_w[1], 0);
        end
`ifdef PISO_PARITY_EN
        run_vec(8'h00, "00000000001");
`else
        run_vec(8'h00, "0000000001");
`endif

        // Random traffic, checked against the per-instance models.
        wait_idle();
        repeat (1500) begin
            @(negedge Clk);
            Load_valid = ($urandom_range(3, 0) == 0);
            Din = 8'($urandom);
        end
        Load_valid = 1'b0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso_serial_tx.md
Name: piso_serial_tx

Overview:
- Parallel-in, serial-out framed transmitter. It produces the single-bit D stream that downstream flip-flop/latch receivers sample on Clk.
- Accepts a WIDTH-bit word through a valid/ready handshake.
- Serialises the word LSB-first, framed by a start bit (0) and a stop bit (1). The line idles high.
- Each serial bit is held for BIT_CYCLES clocks, so slower sampling stages can capture it.

Parameters:
- WIDTH, 8, data bits per frame (1..32).
- BIT_CYCLES, 1, Clk cycles each serial bit is held (1..255).

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-high reset.
- Din  input  WIDTH  parallel word to transmit.
- Load_valid  input  1  Din is valid and requests transmission.
- Load_ready  output  1  transmitter can accept a word.
- SerOut  output  1  serial line, registered; idle high.
- Busy  output  1  a frame is in progress.
- Done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Interface: one clock (Clk); reset Rst is asynchronous and active-high.
- Reset values: SerOut=1, Load_ready=1, Busy=0, Done=0, state=IDLE, shift register=0, bit counter=0, cycle counter=0.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- Handshake:
  - Transfer occurs on a rising edge with Load_valid=1 and Load_ready=1. Din is captured into the shift register at that edge.
  - Load_ready=1 only in IDLE. Load_valid while not ready is ignored, with no effect on the frame in flight.
- IDLE:
  - SerOut=1, Busy=0.
  - On transfer, go to START. SerOut=0 and Busy=1 in the cycle after the transfer edge (latency 1 clock).
- START: SerOut=0 for BIT_CYCLES clocks, then go to DATA.
- DATA:
  - SerOut = shift register bit 0, each bit held BIT_CYCLES clocks.
  - Register shifts right after each bit time.
  - After WIDTH bits, go to PARITY if compiled in, else STOP.
- STOP: SerOut=1 for BIT_CYCLES clocks, then go to IDLE.
- Completion: Done=1 for exactly the first IDLE cycle after STOP. Load_ready=1 in that same cycle, so back-to-back frames have zero idle gap beyond that cycle.
- Counters:
  - Cycle counter counts 0..BIT_CYCLES-1 and wraps to 0 at each bit boundary.
  - Bit counter counts 0..WIDTH-1 in DATA only.
  - Counter width is sized so it never overflows at the parameter maxima.
- Frame length: (WIDTH+2)*BIT_CYCLES clocks from the first START cycle to the last STOP cycle, plus BIT_CYCLES with parity.
- Rst asserted mid-frame: immediate return to reset values (SerOut high without waiting for Clk). The partial frame is discarded; no Done pulse.
- Load_valid held high continuously: a new word is accepted on each Done/IDLE cycle.
- Busy=1 in START, DATA, PARITY and STOP; 0 otherwise.
- Outputs are registered; no combinational path from inputs to SerOut.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - SerOut = even parity (XOR of all WIDTH captured bits), held BIT_CYCLES clocks.
  - Parity is computed from the word captured at the transfer edge.
- Undefined: no PARITY state; DATA goes directly to STOP. No parity logic is synthesised.

Test Plan:
- Reset: assert Rst mid-clock-period with no edge -> SerOut=1, Load_ready=1, Busy=0, Done=0 immediately.
- Single frame (WIDTH=8, BIT_CYCLES=1, no parity):
  - Stimulus: Din=8'hA5, Load_valid pulsed 1 cycle.
  - Required SerOut, one bit per clock starting the cycle after transfer: 0,1,0,1,0,0,1,0,1,1.
  - Busy=1 for 10 cycles; Done=1 on cycle 11; Load_ready=0 during the frame.
- Bit stretching (BIT_CYCLES=4): Din=8'h01 -> each level held 4 clocks (start 4x0, 4x1, 28x0, stop 4x1); frame spans 40 clocks; Done 1 cycle after.
- Back-to-back with ignore-while-busy:
  - Stimulus: Load_valid held high; Din=8'h3C, then 8'hC3 presented from mid-frame onward.
  - Required: first frame sends 8'h3C unaltered; second frame sends 8'hC3 starting the cycle after Done.
  - Exactly 2 transfers counted over 22 cycles.
- Reset mid-frame: Rst asserted during DATA bit 3 of 8'hFF -> SerOut=1 at once, no Done. A new word 8'h00 loaded after release transmits a clean full frame.
- PISO_PARITY_EN defined:
  - Din=8'h07 -> parity bit 1, SerOut 0,1,1,1,0,0,0,0,0,1,1.
  - Din=8'hA5 -> parity bit 0.
  - Frame is 11 cycles with BIT_CYCLES=1.
